axi_strm_mc: RTL and testbench

AXI_STRM_MC -- requirements
Module: axi_strm_mc

---
 rtl/axi_strm_pkg.sv | 32 +++
 rtl/strm_chan.sv | 130 +++++++++++++
 rtl/axi_strm_mc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_strm_mc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_strm_pkg.sv
// Shared types and address-map constants for the multi-channel AXI stream mailbox.
package axi_strm_pkg;

  typedef enum logic {READ_IDLE, READ_DATA} read_state_t;

  typedef enum logic [2:0] {SEL_R, SEL_W, SEL_FR, SEL_FW, SEL_DATA} read_sel_t;

  localparam logic [31:0] OFF_R  = 32'd0;
  localparam logic [31:0] OFF_W  = 32'd64;
  localparam logic [31:0] OFF_FR = 32'd128;
  localparam logic [31:0] OFF_FW = 32'd192;

  localparam logic [4:0] SR_R_CREDS = 5'h00;
  localparam logic [4:0] SR_W_CREDS = 5'h08;
  localparam logic [4:0] SR_FR      = 5'h10;
  localparam logic [4:0] SR_FW      = 5'h18;

  localparam logic [63:0] SR_UNMAPPED = 64'hAAAAAAAA55555555;

  localparam int Q_LD = 4;

  function automatic read_sel_t decode_sel(input logic [31:0] off);
    case (off)
      OFF_R:   return SEL_R;
      OFF_W:   return SEL_W;
      OFF_FR:  return SEL_FR;
      OFF_FW:  return SEL_FW;
      default: return SEL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/strm_chan.sv
// One stream channel: show-ahead FIFO over a registered-read RAM, plus the
// credit/occupancy counters and flush handling.
module strm_chan #(
  parameter int DATA_W   = 512,
  parameter int USER_W   = 1,
  parameter int DEPTH_LD = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W+USER_W-1:0]   push_data,
  input  logic                       pop,
  output logic [DATA_W+USER_W-1:0]   head_data,
  output logic                       head_valid,
  output logic                       full,
  input  logic                       flush,
  input  logic                       r_clr,
  input  logic                       w_clr,
  input  logic                       r_load,
  input  logic                       w_load,
  input  logic [DEPTH_LD:0]          load_val,
  output logic [DEPTH_LD:0]          r_creds,
  output logic [DEPTH_LD:0]          w_creds,
  output logic [DEPTH_LD:0]          fr,
  output logic [DEPTH_LD:0]          fw
);

  localparam int PW = DATA_W + USER_W;
  localparam int CW = DEPTH_LD + 1;
  localparam int DEPTH = 1 << DEPTH_LD;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [DEPTH_LD-1:0] PONE = DEPTH_LD'(1);

  logic [PW-1:0] mem [DEPTH];
  logic [DEPTH_LD-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] ram_cnt_reg;
  logic head_valid_reg;
  logic [PW-1:0] head_data_reg;
  logic [CW-1:0] r_creds_reg, w_creds_reg, fr_reg, fw_reg;
  logic [CW-1:0] r_creds_next, w_creds_next, fr_next, fw_next;
  logic [CW-1:0] load_sat;
  logic do_push, do_pop, fetch;

  assign do_push = push && !flush && (fw_reg != '0);
  assign do_pop  = pop && head_valid_reg && !flush;
  // The head register refills from RAM whenever it is empty or being consumed.
  assign fetch   = (ram_cnt_reg != '0) && (!head_valid_reg || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (fetch) head_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      ram_cnt_reg    <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PONE;
      if (fetch)   rd_ptr_reg <= rd_ptr_reg + PONE;
      case ({do_push, fetch})
        2'b10:   ram_cnt_reg <= ram_cnt_reg + ONE;
        2'b01:   ram_cnt_reg <= ram_cnt_reg - ONE;
        default: ;
      endcase
      if (fetch)       head_valid_reg <= 1'b1;
      else if (do_pop) head_valid_reg <= 1'b0;
    end
  end

  assign load_sat = (load_val > FULL_CNT) ? FULL_CNT : load_val;

  always_comb begin
    r_creds_next = r_creds_reg;
    w_creds_next = w_creds_reg;
    fr_next      = fr_reg;
    fw_next      = fw_reg;
    if (flush) begin
      r_creds_next = '0;
      w_creds_next = FULL_CNT;
      fr_next      = '0;
      fw_next      = FULL_CNT;
    end else begin
      if (r_load)                                r_creds_next = load_sat;
      else if (r_clr)                            r_creds_next = do_push ? ONE : '0;
      else if (do_push && r_creds_reg != FULL_CNT) r_creds_next = r_creds_reg + ONE;

      if (w_load)                                w_creds_next = load_sat;
      else if (w_clr)                            w_creds_next = do_pop ? ONE : '0;
      else if (do_pop && w_creds_reg != FULL_CNT)  w_creds_next = w_creds_reg + ONE;

      if (do_push && !do_pop) begin
        fr_next = fr_reg + ONE;
        fw_next = fw_reg - ONE;
      end else if (do_pop && !do_push) begin
        fr_next = fr_reg - ONE;
        fw_next = fw_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_creds_reg <= '0;
      w_creds_reg <= FULL_CNT;
      fr_reg      <= '0;
      fw_reg      <= FULL_CNT;
    end else begin
      r_creds_reg <= r_creds_next;
      w_creds_reg <= w_creds_next;
      fr_reg      <= fr_next;
      fw_reg      <= fw_next;
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;
  assign full       = (fw_reg == '0);
  assign r_creds    = r_creds_reg;
  assign w_creds    = w_creds_reg;
  assign fr         = fr_reg;
  assign fw         = fw_reg;

endmodule

// File: rtl/axi_strm_mc.sv
// Multi-channel AXI stream mailbox: AXI writes fill per-channel FIFOs, AXI reads
// drain them or return status counters; a soft-register port exposes the counters.
module axi_strm_mc
  import axi_strm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 512,
  parameter int USER_W   = 1,
  parameter int DEPTH_LD = 10,
  parameter int ID_W     = 16,
  parameter int CH_SHIFT = 12,
  parameter int ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sr_req_valid,
  input  logic              sr_req_write,
  input  logic [31:0]       sr_req_addr,
  input  logic [63:0]       sr_req_data,
  output logic              sr_resp_valid,
  output logic [63:0]       sr_resp_data,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [USER_W-1:0] ruser,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [USER_W-1:0] wuser,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int CH_LD = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW    = DEPTH_LD + 1;
  localparam int PW    = DATA_W + USER_W;
  localparam int QD    = 1 << Q_LD;
  localparam logic [Q_LD:0] QONE = (Q_LD+1)'(1);

  function automatic logic [CH_LD-1:0] ch_of(input logic [ADDR_W-1:0] a);
    return (NUM_CH == 1) ? '0 : a[CH_SHIFT +: CH_LD];
  endfunction

  logic [NUM_CH-1:0] push, pop, flush, r_clr, w_clr, r_load, w_load, head_valid, full;
  logic [PW-1:0] head_data [NUM_CH];
  logic [CW-1:0] r_creds [NUM_CH];
  logic [CW-1:0] w_creds [NUM_CH];
  logic [CW-1:0] fr [NUM_CH];
  logic [CW-1:0] fw [NUM_CH];

  // Soft-register decode: 0x20 bytes per channel, 64-bit aligned registers.
  logic [CH_LD-1:0] sr_ch;
  logic [4:0] sr_off;
  logic sr_hit, sr_rd;
  logic [63:0] sr_rd_val;
  logic sr_resp_valid_reg;
  logic [63:0] sr_resp_data_reg;

  assign sr_ch  = sr_req_addr[5 +: CH_LD];
  assign sr_off = sr_req_addr[4:0];
  assign sr_hit = ({5'b0, sr_req_addr[31:5]} < 32'(NUM_CH)) && (sr_req_addr[2:0] == 3'b0);
  assign sr_rd  = sr_req_valid && !sr_req_write;

  always_comb begin
    sr_rd_val = SR_UNMAPPED;
    if (sr_hit) begin
      case (sr_off)
        SR_R_CREDS: sr_rd_val = 64'(r_creds[sr_ch]);
        SR_W_CREDS: sr_rd_val = 64'(w_creds[sr_ch]);
        SR_FR:      sr_rd_val = 64'(fr[sr_ch]);
        SR_FW:      sr_rd_val = 64'(fw[sr_ch]);
        default:    sr_rd_val = SR_UNMAPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_resp_valid_reg <= 1'b0;
    else     sr_resp_valid_reg <= sr_rd;
    if (sr_rd) sr_resp_data_reg <= sr_rd_val;
  end

  assign sr_resp_valid = sr_resp_valid_reg;
  assign sr_resp_data  = sr_resp_data_reg;

  // Read side
  read_state_t state_reg, state_next;
  logic [ID_W-1:0] rd_id_reg;
  logic [7:0] rd_len_reg;
  logic [CH_LD-1:0] rd_ch_reg;
  read_sel_t rd_sel_reg;
  logic r_fire;

  assign r_fire = rvalid && rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= READ_IDLE;
    end else begin
      state_reg <= state_next;
      if (arvalid && arready) begin
        rd_id_reg  <= arid;
        rd_len_reg <= arlen;
        rd_ch_reg  <= ch_of(araddr);
        rd_sel_reg <= decode_sel(32'(araddr[CH_SHIFT-1:0]));
      end else if (r_fire) begin
        rd_len_reg <= rd_len_reg - 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    ruser      = '0;
    case (state_reg)
      READ_IDLE: begin
        arready = 1'b1;
        if (arvalid) state_next = READ_DATA;
      end
      READ_DATA: begin
        if (!flush[rd_ch_reg])
          rvalid = (rd_sel_reg == SEL_DATA) ? head_valid[rd_ch_reg] : 1'b1;
        case (rd_sel_reg)
          SEL_R:   rdata = DATA_W'(r_creds[rd_ch_reg]);
          SEL_W:   rdata = DATA_W'(w_creds[rd_ch_reg]);
          SEL_FR:  rdata = DATA_W'(fr[rd_ch_reg]);
          SEL_FW:  rdata = DATA_W'(fw[rd_ch_reg]);
          default: {ruser, rdata} = head_data[rd_ch_reg];
        endcase
        if (rvalid && rready && rd_len_reg == 8'd0) state_next = READ_IDLE;
      end
      default: state_next = READ_IDLE;
    endcase
  end

  assign rid   = rd_id_reg;
  assign rlast = (rd_len_reg == 8'd0);
  assign rresp = 2'b00;

  // Write side: AW queue steers W beats, B queue returns ids in AW order.
  logic [ID_W-1:0]  aq_id_mem [QD];
  logic [CH_LD-1:0] aq_ch_mem [QD];
  logic             aq_dat_mem [QD];
  logic [Q_LD:0]    aq_wptr_reg, aq_rptr_reg;
  logic [ID_W-1:0]  bq_id_mem [QD];
  logic [Q_LD:0]    bq_wptr_reg, bq_rptr_reg;
  logic awq_full, awq_empty, bq_full, bq_empty;
  logic [CH_LD-1:0] head_ch;
  logic head_dat, aw_fire, w_fire, w_done, b_fire;

  assign awq_empty = (aq_wptr_reg == aq_rptr_reg);
  assign awq_full  = (aq_wptr_reg[Q_LD] != aq_rptr_reg[Q_LD]) &&
                     (aq_wptr_reg[Q_LD-1:0] == aq_rptr_reg[Q_LD-1:0]);
  assign bq_empty  = (bq_wptr_reg == bq_rptr_reg);
  assign bq_full   = (bq_wptr_reg[Q_LD] != bq_rptr_reg[Q_LD]) &&
                     (bq_wptr_reg[Q_LD-1:0] == bq_rptr_reg[Q_LD-1:0]);
  assign head_ch   = aq_ch_mem[aq_rptr_reg[Q_LD-1:0]];
  assign head_dat  = aq_dat_mem[aq_rptr_reg[Q_LD-1:0]];

  assign awready = !awq_full;
  assign wready  = !awq_empty && !full[head_ch] && !flush[head_ch] && !bq_full;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign w_done  = w_fire && wlast;
  assign bvalid  = !bq_empty;
  assign b_fire  = bvalid && bready;
  assign bid     = bq_id_mem[bq_rptr_reg[Q_LD-1:0]];
  assign bresp   = 2'b00;

  always_ff @(posedge clk) begin
    if (aw_fire) begin
      aq_id_mem[aq_wptr_reg[Q_LD-1:0]]  <= awid;
      aq_ch_mem[aq_wptr_reg[Q_LD-1:0]]  <= ch_of(awaddr);
      aq_dat_mem[aq_wptr_reg[Q_LD-1:0]] <= (decode_sel(32'(awaddr[CH_SHIFT-1:0])) == SEL_DATA);
    end
    if (w_done) bq_id_mem[bq_wptr_reg[Q_LD-1:0]] <= aq_id_mem[aq_rptr_reg[Q_LD-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aq_wptr_reg <= '0;
      aq_rptr_reg <= '0;
      bq_wptr_reg <= '0;
      bq_rptr_reg <= '0;
    end else begin
      if (aw_fire) aq_wptr_reg <= aq_wptr_reg + QONE;
      if (w_done) begin
        aq_rptr_reg <= aq_rptr_reg + QONE;
        bq_wptr_reg <= bq_wptr_reg + QONE;
      end
      if (b_fire) bq_rptr_reg <= bq_rptr_reg + QONE;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [CH_LD-1:0] CH_IDX = CH_LD'(gi);
    logic sr_sel, rd_here;

    assign sr_sel  = sr_req_valid && sr_hit && (sr_ch == CH_IDX);
    assign rd_here = r_fire && (rd_ch_reg == CH_IDX);

    assign flush[gi]  = sr_sel && sr_req_write && (sr_off == SR_FW);
    assign r_load[gi] = sr_sel && sr_req_write && (sr_off == SR_R_CREDS);
    assign w_load[gi] = sr_sel && sr_req_write && (sr_off == SR_W_CREDS);
    assign r_clr[gi]  = (sr_sel && !sr_req_write && (sr_off == SR_R_CREDS)) ||
                        (rd_here && rd_sel_reg == SEL_R);
    assign w_clr[gi]  = (sr_sel && !sr_req_write && (sr_off == SR_W_CREDS)) ||
                        (rd_here && rd_sel_reg == SEL_W);
    assign pop[gi]    = rd_here && (rd_sel_reg == SEL_DATA);
    assign push[gi]   = w_fire && head_dat && (head_ch == CH_IDX);

    strm_chan #(
      .DATA_W   (DATA_W),
      .USER_W   (USER_W),
      .DEPTH_LD (DEPTH_LD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .push       (push[gi]),
      .push_data  ({wuser, wdata}),
      .pop        (pop[gi]),
      .head_data  (head_data[gi]),
      .head_valid (head_valid[gi]),
      .full       (full[gi]),
      .flush      (flush[gi]),
      .r_clr      (r_clr[gi]),
      .w_clr      (w_clr[gi]),
      .r_load     (r_load[gi]),
      .w_load     (w_load[gi]),
      .load_val   (sr_req_data[CW-1:0]),
      .r_creds    (r_creds[gi]),
      .w_creds    (w_creds[gi]),
      .fr         (fr[gi]),
      .fw         (fw[gi])
    );
  end

  // Address bits above the channel field and the upper SR write data are ignored.
  logic unused;
  assign unused = ^{araddr[ADDR_W-1:CH_SHIFT+CH_LD], awaddr[ADDR_W-1:CH_SHIFT+CH_LD],
                    sr_req_data[63:CW]};

endmodule

// File: tb/tb_axi_strm_mc.sv
// Scoreboard bench for axi_strm_mc: stimulus pushes expected R/B/SR responses,
// monitors pop and compare whenever the DUT presents a response.
module tb_axi_strm_mc;

  localparam int ID_W = 16;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst;
  logic sr_req_valid, sr_req_write, sr_resp_valid;
  logic [31:0] sr_req_addr;
  logic [63:0] sr_req_data, sr_resp_data;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [63:0] araddr, awaddr;
  logic [7:0] arlen;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [0:0] ruser, wuser;
  logic [1:0] rresp, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_strm_mc #(
    .NUM_CH(4), .DATA_W(DW), .USER_W(1), .DEPTH_LD(4),
    .ID_W(ID_W), .CH_SHIFT(12), .ADDR_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .sr_req_valid(sr_req_valid), .sr_req_write(sr_req_write),
    .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
    .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .ruser(ruser), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wuser(wuser), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        user;
    logic        last;
    logic [15:0] id;
  } r_item_t;

  r_item_t     r_q[$];
  logic [15:0] b_q[$];
  logic [63:0] sr_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_timeout(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endfunction

  function automatic void exp_r(logic [63:0] d, logic u, logic l, logic [15:0] id);
    r_item_t it;
    it.data = d; it.user = u; it.last = l; it.id = id;
    r_q.push_back(it);
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          fail_timeout("r_unexpected");
        end else begin
          r_item_t e;
          e = r_q.pop_front();
          check("r_data", {rdata, ruser}, {e.data, e.user});
          check("r_last_id", {rlast, rid, rresp}, {e.last, e.id, 2'b00});
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) fail_timeout("b_unexpected");
        else check("b_id", {bid, bresp}, {b_q.pop_front(), 2'b00});
      end
      if (sr_resp_valid) begin
        if (sr_q.size() == 0) fail_timeout("sr_unexpected");
        else check("sr_data", sr_resp_data, sr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [15:0] id, input logic [63:0] addr);
    int n = 0;
    logic ok;
    awid = id; awaddr = addr; awvalid = 1'b1;
    do begin @(negedge clk); ok = awready; @(posedge clk); n++; end while (!ok && n < 500);
    #1 awvalid = 1'b0;
    if (!ok) fail_timeout("aw_wait");
  endtask

  task automatic w_send(input logic [63:0] d, input logic last);
    int n = 0;
    logic ok;
    wdata = d; wuser = d[0]; wlast = last; wvalid = 1'b1;
    do begin @(negedge clk); ok = wready; @(posedge clk); n++; end while (!ok && n < 500);
    #1 wvalid = 1'b0;
    if (!ok) fail_timeout("w_wait");
  endtask

  task automatic ar_send(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    logic ok;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    do begin @(negedge clk); ok = arready; @(posedge clk); n++; end while (!ok && n < 500);
    #1 arvalid = 1'b0;
    if (!ok) fail_timeout("ar_wait");
  endtask

  task automatic sr_read(input logic [31:0] addr, input logic [63:0] exp);
    sr_q.push_back(exp);
    sr_req_valid = 1'b1; sr_req_write = 1'b0; sr_req_addr = addr;
    tick();
    sr_req_valid = 1'b0;
  endtask

  task automatic sr_write(input logic [31:0] addr, input logic [63:0] d);
    sr_req_valid = 1'b1; sr_req_write = 1'b1; sr_req_addr = addr; sr_req_data = d;
    tick();
    sr_req_valid = 1'b0; sr_req_write = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin tick(); n++; end
    while ((r_q.size() + b_q.size() + sr_q.size()) != 0 && n < 2000);
    if (n >= 2000) fail_timeout("drain");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sr_req_valid = 0; sr_req_write = 0; sr_req_addr = '0; sr_req_data = '0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 1;
    awid = '0; awaddr = '0; awvalid = 0;
    wdata = '0; wuser = '0; wlast = 0; wvalid = 0; bready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_arready", arready, 1'b1);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_sr_valid", sr_resp_valid, 1'b0);
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b0);
    @(posedge clk); #1;
    sr_read(32'h00, 64'd0);
    sr_read(32'h08, 64'd16);
    sr_read(32'h10, 64'd0);
    sr_read(32'h18, 64'd16);
    sr_read(32'h80, 64'hAAAAAAAA55555555);
    sr_read(32'h04, 64'hAAAAAAAA55555555);
    wait_drain();

    // 4-beat burst into ch2, credit counters and read-clear
    aw_send(16'd1, 64'h2100);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) b_q.push_back(16'd1);
      w_send(64'h200 + 64'(i), i == 4);
    end
    wait_drain();
    sr_read(32'h40, 64'd4);
    sr_read(32'h50, 64'd4);
    sr_read(32'h40, 64'd0);
    sr_read(32'h48, 64'd16);
    for (int i = 1; i <= 4; i++) exp_r(64'h200 + 64'(i), i[0], i == 4, 16'd2);
    ar_send(16'd2, 64'h2100, 8'd3);
    wait_drain();
    sr_read(32'h48, 64'd4);
    sr_read(32'h58, 64'd16);
    wait_drain();

    // Fill ch0 past capacity, drain concurrently
    aw_send(16'd3, 64'h0100);
    for (int i = 1; i <= 16; i++) w_send(64'h300 + 64'(i), 1'b0);
    wdata = 64'h311; wuser = 1'b1; wlast = 1'b0; wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wready_full", wready, 1'b0);
      @(posedge clk); #1;
    end
    sr_read(32'h10, 64'd16);
    fork
      begin
        for (int i = 1; i <= 16; i++) exp_r(64'h300 + 64'(i), i[0], i == 16, 16'd4);
        ar_send(16'd4, 64'h0100, 8'd15);
      end
      begin
        for (int i = 17; i <= 20; i++) begin
          if (i == 20) b_q.push_back(16'd3);
          w_send(64'h300 + 64'(i), i == 20);
        end
      end
    join
    wait_drain();
    for (int i = 17; i <= 20; i++) exp_r(64'h300 + 64'(i), i[0], i == 20, 16'd5);
    ar_send(16'd5, 64'h0100, 8'd3);
    wait_drain();

    // Two outstanding AWs routed in order
    aw_send(16'd5, 64'h1100);
    aw_send(16'd9, 64'h3100);
    w_send(64'h501, 1'b0);
    b_q.push_back(16'd5);
    w_send(64'h502, 1'b1);
    w_send(64'h901, 1'b0);
    b_q.push_back(16'd9);
    w_send(64'h902, 1'b1);
    wait_drain();
    sr_read(32'h30, 64'd2);
    sr_read(32'h70, 64'd2);
    sr_read(32'h20, 64'd2);
    exp_r(64'h901, 1'b1, 1'b0, 16'd6);
    exp_r(64'h902, 1'b0, 1'b1, 16'd6);
    ar_send(16'd6, 64'h3100, 8'd1);
    wait_drain();

    // Status read of ch1 r_creds coinciding with a W beat into ch1
    aw_send(16'd6, 64'h1100);
    b_q.push_back(16'd6);
    w_send(64'h601, 1'b1);
    aw_send(16'd7, 64'h1100);
    b_q.push_back(16'd7);
    rready = 1'b0;
    exp_r(64'd1, 1'b0, 1'b1, 16'd8);
    ar_send(16'd8, 64'h1000, 8'd0);
    wdata = 64'h701; wuser = 1'b1; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("coincide_ready", {wready, rvalid}, 2'b11);
    @(posedge clk); #1;
    wvalid = 1'b0;
    wait_drain();
    sr_read(32'h20, 64'd1);
    sr_read(32'h30, 64'd4);
    wait_drain();

    // Flush ch3 via soft register
    aw_send(16'd11, 64'h3100);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) b_q.push_back(16'd11);
      w_send(64'hB00 + 64'(i), i == 8);
    end
    wait_drain();
    sr_read(32'h70, 64'd8);
    sr_write(32'h78, 64'd0);
    sr_read(32'h70, 64'd0);
    sr_read(32'h78, 64'd16);
    sr_read(32'h60, 64'd0);
    sr_read(32'h68, 64'd16);
    wait_drain();
    ar_send(16'd12, 64'h3100, 8'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_rvalid", rvalid, 1'b0);
      @(posedge clk); #1;
    end
    exp_r(64'hC01, 1'b1, 1'b1, 16'd12);
    aw_send(16'd13, 64'h3100);
    b_q.push_back(16'd13);
    w_send(64'hC01, 1'b1);
    wait_drain();

    // Reset in the middle of a 4-beat read
    aw_send(16'd14, 64'h0100);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) b_q.push_back(16'd14);
      w_send(64'hE00 + 64'(i), i == 4);
    end
    wait_drain();
    rready = 1'b0;
    ar_send(16'd15, 64'h0100, 8'd3);
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_rvalid", rvalid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_arready", arready, 1'b1);
    check("mid_rst_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    rready = 1'b1;
    sr_read(32'h10, 64'd0);
    sr_read(32'h30, 64'd0);
    sr_read(32'h50, 64'd0);
    sr_read(32'h70, 64'd0);
    sr_read(32'h18, 64'd16);
    repeat (10) tick();
    wait_drain();

    check("leftover", 128'(r_q.size() + b_q.size() + sr_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
